// File: rtl/lock_core_multislot.sv
// lock_core_multislot: multi-slot password lock with run-time slot select,
// inactivity timeout and exponentially growing lockout after failures.
module lock_core_multislot #(
  parameter int unsigned MAX_LEN      = 8,
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned PASS_CYCLES  = 36,
  parameter int unsigned FAIL_CYCLES  = 36,
  parameter int unsigned BASE_LOCK    = 90,
  parameter int unsigned MAX_SHIFT    = 3,
  parameter int unsigned IDLE_TIMEOUT = 360,
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enter0,
  input  logic                         enter1,
  input  logic                         confirm,
  input  logic                         clear,
  input  logic                         algorithm_select_mode,
  input  logic [NUM_SLOTS*MAX_LEN-1:0] pw_table,
  input  logic [NUM_SLOTS*LW-1:0]      len_table,
  output logic                         unlocked,
  output logic                         fail,
  output logic                         locked,
  output logic                         entering,
  output logic                         mode_sel,
  output logic                         sel_pending,
  output logic [SW-1:0]                active_slot,
  output logic [LW-1:0]                entry_count,
  output logic [3:0]                   fail_count
);

  localparam int unsigned LOCK_MAX = BASE_LOCK << MAX_SHIFT;
  localparam int unsigned T_A      = (PASS_CYCLES > FAIL_CYCLES) ? PASS_CYCLES : FAIL_CYCLES;
  localparam int unsigned T_B      = (LOCK_MAX > IDLE_TIMEOUT) ? LOCK_MAX : IDLE_TIMEOUT;
  localparam int unsigned T_MAX    = (T_A > T_B) ? T_A : T_B;
  localparam int unsigned TW       = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_PASS, S_FAIL, S_LOCK, S_MODE
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           prev_q;
  logic [MAX_LEN-1:0]   code_q, code_d;
  logic                 ovf_q, ovf_d;
  logic [SW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [LW-1:0]        cnt_d;
  logic [SW-1:0]        slot_d;
  logic [3:0]           fc_d;
  logic                 selp_d;

  logic [4:0]           btn, rise;
  logic                 p_clr, p_cfm, p_sel, p_ent, p_bit, hi_none;
  logic [MAX_LEN-1:0]   pw_sel, mask;
  logic [LW-1:0]        len_sel;
  logic                 match;
  logic [3:0]           fc_m1;
  logic [TW-1:0]        lock_len;

  // Rising-edge detection and priority resolution of the buttons
  always_comb begin
    btn     = {algorithm_select_mode, clear, confirm, enter1, enter0};
    rise    = btn & ~prev_q;
    p_clr   = rise[3];
    p_cfm   = rise[2] & ~rise[3];
    p_sel   = rise[4] & ~rise[3] & ~rise[2];
    hi_none = ~rise[4] & ~rise[3] & ~rise[2];
    p_ent   = hi_none & (rise[1] ^ rise[0]);
    p_bit   = rise[1];
  end

  // Password comparison against the active slot
  always_comb begin
    pw_sel  = '0;
    len_sel = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (active_slot == SW'(k)) begin
        pw_sel  = pw_table[k*MAX_LEN +: MAX_LEN];
        len_sel = len_table[k*LW +: LW];
      end
    end
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LW'(i) < len_sel);
    match = ~ovf_q && (entry_count == len_sel) && (((code_q ^ pw_sel) & mask) == '0);
  end

  // Lockout length doubles per consecutive failure up to the cap
  always_comb begin
    fc_m1 = fail_count - 4'd1;
    if (32'(fc_m1) >= MAX_SHIFT) lock_len = TW'(LOCK_MAX);
    else                         lock_len = TW'(BASE_LOCK << fc_m1);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = entry_count;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    slot_d  = active_slot;
    fc_d    = fail_count;
    selp_d  = sel_pending;
    tmr_d   = tmr_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (p_ent) begin
          state_d = S_ENTRY;
          code_d  = MAX_LEN'(p_bit);
          cnt_d   = LW'(1);
        end else if (p_sel) begin
          selp_d = 1'b1;
        end else if (p_clr) begin
          selp_d = 1'b0;
        end
      end
      S_ENTRY: begin
        if (p_clr || p_cfm) begin
          code_d = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          tmr_d  = '0;
          if (p_clr) begin
            state_d = S_IDLE;
          end else if (match) begin
            state_d = S_PASS;
            fc_d    = '0;
          end else begin
            state_d = S_FAIL;
            fc_d    = (fail_count == 4'd15) ? 4'd15 : fail_count + 4'd1;
            selp_d  = 1'b0;
          end
        end else if (p_sel) begin
          selp_d = 1'b1;
          tmr_d  = '0;
        end else if (p_ent) begin
          code_d = MAX_LEN'({code_q, p_bit});
          if (entry_count == LW'(MAX_LEN)) ovf_d = 1'b1;
          else                             cnt_d = entry_count + LW'(1);
          tmr_d = '0;
        end else if (tmr_q == TW'(IDLE_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          code_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          selp_d  = 1'b0;
          tmr_d   = '0;
        end
      end
      S_PASS: begin
        if (tmr_q == TW'(PASS_CYCLES - 1)) begin
          tmr_d = '0;
          if (sel_pending) begin
            state_d = S_MODE;
            selp_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FAIL: begin
        if (tmr_q == TW'(FAIL_CYCLES - 1)) begin
          state_d = S_LOCK;
          tmr_d   = '0;
        end
      end
      S_LOCK: begin
        if (tmr_q == lock_len - TW'(1)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      end
      S_MODE: begin
        if (p_clr) begin
          idx_d = '0;
          tmr_d = '0;
        end else if (p_cfm) begin
          if (32'(idx_q) < NUM_SLOTS) slot_d = idx_q;
          idx_d   = '0;
          state_d = S_IDLE;
          tmr_d   = '0;
        end else if (p_ent) begin
          idx_d = SW'({idx_q, p_bit});
          tmr_d = '0;
        end else if (tmr_q == TW'(IDLE_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
          selp_d  = 1'b0;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      code_q      <= '0;
      ovf_q       <= 1'b0;
      idx_q       <= '0;
      tmr_q       <= '0;
      entry_count <= '0;
      active_slot <= '0;
      fail_count  <= '0;
      sel_pending <= 1'b0;
      unlocked    <= 1'b0;
      fail        <= 1'b0;
      locked      <= 1'b0;
      entering    <= 1'b0;
      mode_sel    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= btn;
      code_q      <= code_d;
      ovf_q       <= ovf_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      entry_count <= cnt_d;
      active_slot <= slot_d;
      fail_count  <= fc_d;
      sel_pending <= selp_d;
      unlocked    <= (state_d == S_PASS);
      fail        <= (state_d == S_FAIL);
      locked      <= (state_d == S_LOCK);
      entering    <= (state_d == S_ENTRY);
      mode_sel    <= (state_d == S_MODE);
    end
  end

endmodule

// File: tb/tb_lock_core_multislot.sv
// Testbench for lock_core_multislot: directed scenarios plus random button
// traffic, all checked every cycle against a behavioural model.
module tb_lock_core_multislot;

  localparam int MAX_LEN = 8, NUM_SLOTS = 3, LW = 4, SW = 2;
  localparam int PASS_C = 36, FAIL_C = 36, BASE_LOCK = 90, MAX_SHIFT = 3, TO = 360;
  localparam int B_E0 = 0, B_E1 = 1, B_CFM = 2, B_CLR = 3, B_SEL = 4;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_PASS = 2, M_FAIL = 3, M_LOCK = 4, M_MODE = 5;
  localparam int EV_NONE = 0, EV_CLR = 1, EV_CFM = 2, EV_SEL = 3, EV_E0 = 4, EV_E1 = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enter0 = 0, enter1 = 0, confirm = 0, clear = 0, algorithm_select_mode = 0;
  logic [NUM_SLOTS*MAX_LEN-1:0] pw_table;
  logic [NUM_SLOTS*LW-1:0]      len_table;
  logic unlocked, fail, locked, entering, mode_sel, sel_pending;
  logic [SW-1:0] active_slot;
  logic [LW-1:0] entry_count;
  logic [3:0]    fail_count;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  lock_core_multislot #(
    .MAX_LEN(MAX_LEN), .NUM_SLOTS(NUM_SLOTS), .PASS_CYCLES(PASS_C), .FAIL_CYCLES(FAIL_C),
    .BASE_LOCK(BASE_LOCK), .MAX_SHIFT(MAX_SHIFT), .IDLE_TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .enter0(enter0), .enter1(enter1), .confirm(confirm),
    .clear(clear), .algorithm_select_mode(algorithm_select_mode),
    .pw_table(pw_table), .len_table(len_table), .unlocked(unlocked), .fail(fail),
    .locked(locked), .entering(entering), .mode_sel(mode_sel), .sel_pending(sel_pending),
    .active_slot(active_slot), .entry_count(entry_count), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  int m_st = M_IDLE, m_rem = 0, m_fc = 0, m_slot = 0, m_idx = 0, m_cyc = 0, m_last = 0;
  bit m_selp = 0;
  bit m_q[$];
  bit [4:0] m_prev = '0;

  function automatic int slot_len(int s);
    return int'(len_table[s*LW +: LW]);
  endfunction

  function automatic int slot_pw(int s);
    return int'(pw_table[s*MAX_LEN +: MAX_LEN]);
  endfunction

  // Entered sequence must equal the stored password, first-entered bit = MSB
  function automatic bit m_match();
    int len, pw;
    len = slot_len(m_slot);
    pw  = slot_pw(m_slot);
    if (m_q.size() != len) return 0;
    for (int i = 0; i < len; i++) if (m_q[i] != pw[len-1-i]) return 0;
    return 1;
  endfunction

  function automatic void m_reset();
    m_st = M_IDLE; m_rem = 0; m_fc = 0; m_slot = 0; m_idx = 0; m_cyc = 0; m_last = 0;
    m_selp = 0; m_q.delete(); m_prev = '0;
  endfunction

  function automatic void m_step();
    bit [4:0] cur, r;
    int ev, sh;
    cur = {algorithm_select_mode, clear, confirm, enter1, enter0};
    r = cur & ~m_prev;
    m_prev = cur;
    m_cyc++;
    ev = EV_NONE;
    if (r[3]) ev = EV_CLR;
    else if (r[2]) ev = EV_CFM;
    else if (r[4]) ev = EV_SEL;
    else if (r[1] && !r[0]) ev = EV_E1;
    else if (r[0] && !r[1]) ev = EV_E0;
    case (m_st)
      M_IDLE: begin
        if (ev == EV_E0 || ev == EV_E1) begin
          m_st = M_ENTRY; m_q.delete(); m_q.push_back(ev == EV_E1); m_last = m_cyc;
        end else if (ev == EV_SEL) m_selp = 1;
        else if (ev == EV_CLR) m_selp = 0;
      end
      M_ENTRY: begin
        if (ev != EV_NONE) begin
          m_last = m_cyc;
          if (ev == EV_CLR) begin
            m_st = M_IDLE; m_q.delete();
          end else if (ev == EV_CFM) begin
            if (m_match()) begin
              m_st = M_PASS; m_rem = PASS_C; m_fc = 0;
            end else begin
              m_st = M_FAIL; m_rem = FAIL_C; m_fc = (m_fc < 15) ? m_fc + 1 : 15; m_selp = 0;
            end
            m_q.delete();
          end else if (ev == EV_SEL) m_selp = 1;
          else m_q.push_back(ev == EV_E1);
        end else if (m_cyc - m_last == TO) begin
          m_st = M_IDLE; m_q.delete(); m_selp = 0;
        end
      end
      M_PASS: begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_selp) begin
            m_st = M_MODE; m_selp = 0; m_idx = 0; m_last = m_cyc;
          end else m_st = M_IDLE;
        end
      end
      M_FAIL: begin
        m_rem--;
        if (m_rem == 0) begin
          sh = (m_fc - 1 < MAX_SHIFT) ? m_fc - 1 : MAX_SHIFT;
          m_st = M_LOCK; m_rem = BASE_LOCK * (1 << sh);
        end
      end
      M_LOCK: begin
        m_rem--;
        if (m_rem == 0) m_st = M_IDLE;
      end
      default: begin
        if (ev != EV_NONE && ev != EV_SEL) begin
          m_last = m_cyc;
          if (ev == EV_CLR) m_idx = 0;
          else if (ev == EV_CFM) begin
            if (m_idx < NUM_SLOTS) m_slot = m_idx;
            m_idx = 0; m_st = M_IDLE;
          end else m_idx = (m_idx * 2 + (ev == EV_E1 ? 1 : 0)) % (1 << SW);
        end else if (m_cyc - m_last == TO) begin
          m_st = M_IDLE; m_idx = 0; m_selp = 0;
        end
      end
    endcase
  endfunction

  // Model advances on the same edges as the design
  always @(posedge clock or posedge reset) begin
    if (reset) m_reset();
    else m_step();
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    int e_cnt;
    if (!reset && chk_en) begin
      e_cnt = (m_q.size() > MAX_LEN) ? MAX_LEN : m_q.size();
      n_cmp++;
      if (unlocked !== (m_st == M_PASS) || fail !== (m_st == M_FAIL) || locked !== (m_st == M_LOCK) ||
          entering !== (m_st == M_ENTRY) || mode_sel !== (m_st == M_MODE) || sel_pending !== m_selp ||
          int'(active_slot) != m_slot || int'(entry_count) != e_cnt || int'(fail_count) != m_fc) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t got u%0b f%0b l%0b e%0b m%0b sp%0b slot%0d cnt%0d fc%0d required u%0b f%0b l%0b e%0b m%0b sp%0b slot%0d cnt%0d fc%0d",
                 $time, unlocked, fail, locked, entering, mode_sel, sel_pending, active_slot, entry_count, fail_count,
                 m_st == M_PASS, m_st == M_FAIL, m_st == M_LOCK, m_st == M_ENTRY, m_st == M_MODE, m_selp, m_slot, e_cnt, m_fc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_E0:  enter0 = v;
      B_E1:  enter1 = v;
      B_CFM: confirm = v;
      B_CLR: clear = v;
      default: algorithm_select_mode = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge clock); set_btn(b, 1'b1);
    @(negedge clock); set_btn(b, 1'b0);
  endtask

  task automatic type_bits(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) press(v[i] ? B_E1 : B_E0);
  endtask

  function automatic bit sig(input int w);
    case (w)
      0: return unlocked;
      1: return fail;
      2: return locked;
      3: return entering;
      default: return mode_sel;
    endcase
  endfunction

  // Waits (bounded) for a status signal to rise, then counts its high cycles
  task automatic measure(input int w, output int n);
    int guard;
    guard = 0; n = 0;
    while (!sig(w) && guard < 3000) begin @(negedge clock); guard++; end
    while (sig(w) && n < 3000) begin n++; @(negedge clock); end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a, lim;
    int exp_lock[4] = '{90, 180, 360, 720};
    pw_table  = {8'h34, 8'h03, 8'h2D};
    len_table = {4'd6, 4'd4, 4'd6};
    repeat (3) @(negedge clock);
    chk("rst_locked", locked, 0);
    chk("rst_entering", entering, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_active_slot", active_slot, 0);
    chk("rst_entry_count", entry_count, 0);
    chk("rst_sel_pending", sel_pending, 0);
    reset = 1'b0;
    chk_en = 1;

    // correct entry on slot 0
    type_bits(6'b101101, 6); press(B_CFM);
    measure(0, n); chk("pass_len", n, 36);
    chk("pass_fc", fail_count, 0);

    // four consecutive failures with growing lockout
    for (int i = 1; i <= 4; i++) begin
      type_bits(6'b111111, 6); press(B_CFM);
      measure(1, n); chk("fail_len", n, 36);
      chk("fail_count_step", fail_count, i);
      measure(2, n); chk("lock_len", n, exp_lock[i-1]);
    end

    // inactivity timeout leaves fail_count alone
    press(B_E1); press(B_E0);
    measure(3, n); chk("timeout_len", n, 360);
    chk("timeout_cnt", entry_count, 0);
    chk("timeout_fc", fail_count, 4);

    type_bits(6'b101101, 6); press(B_CFM);
    measure(0, n); chk("pass_after_fails", n, 36);
    chk("fc_cleared", fail_count, 0);

    // clear then correct entry
    press(B_E1); press(B_E0); press(B_CLR);
    chk("clear_idle", entering, 0);
    type_bits(6'b101101, 6); press(B_CFM);
    measure(0, n); chk("pass_after_clear", n, 36);

    // mode select into slot 2
    press(B_SEL); chk("sel_pending_set", sel_pending, 1);
    type_bits(6'b101101, 6); press(B_CFM);
    measure(0, n); chk("pass_before_mode", n, 36);
    chk("mode_sel_on", mode_sel, 1);
    type_bits(3'b010, 3); press(B_CFM);
    chk("slot_sel_2", active_slot, 2);
    chk("mode_sel_off", mode_sel, 0);
    type_bits(6'b110100, 6); press(B_CFM);
    measure(0, n); chk("pass_slot2", n, 36);
    type_bits(6'b101101, 6); press(B_CFM);
    measure(1, n); chk("fail_slot2_old_pw", n, 36);
    measure(2, n); chk("lock_slot2", n, 90);

    // out-of-range index is ignored
    press(B_SEL); type_bits(6'b110100, 6); press(B_CFM);
    measure(0, n);
    chk("mode_sel_idx3", mode_sel, 1);
    type_bits(2'b11, 2); press(B_CFM);
    chk("slot_idx3_ignored", active_slot, 2);

    // overflow and over-length entries
    type_bits(9'b110100101, 9);
    chk("count_saturates", entry_count, 8);
    press(B_CFM);
    measure(1, n); chk("fail_ovf", n, 36);
    measure(2, n); chk("lock_ovf", n, 90);
    type_bits(7'b1101001, 7); press(B_CFM);
    measure(1, n); chk("fail_extra_bit", n, 36);
    chk("fc_after_extra", fail_count, 2);
    measure(2, n); chk("lock_extra", n, 180);

    // simultaneous enter0/enter1 are dropped
    @(negedge clock); enter0 = 1; enter1 = 1;
    @(negedge clock); chk("dual_enter_dropped", entering, 0);
    enter0 = 0; enter1 = 0;

    // button held from LOCK into IDLE is not a press
    type_bits(6'b000000, 6); press(B_CFM);
    measure(1, n);
    enter1 = 1;
    measure(2, n); chk("lock_360", n, 360);
    chk("held_no_press", entering, 0);
    idle(2); chk("held_no_press2", entering, 0);
    enter1 = 0;

    // asynchronous reset mid-lock
    type_bits(6'b000000, 6); press(B_CFM);
    measure(1, n);
    idle(50);
    chk("in_lock", locked, 1);
    @(posedge clock); #2 reset = 1'b1;
    #1 chk("reset_mid_lock", locked, 0);
    chk("reset_fc", fail_count, 0);
    @(negedge clock); @(negedge clock); reset = 1'b0;

    // random traffic with random tables
    for (int r = 0; r < 3; r++) begin
      @(negedge clock);
      for (int s = 0; s < NUM_SLOTS; s++) begin
        pw_table[s*MAX_LEN +: MAX_LEN] = 8'($urandom);
        len_table[s*LW +: LW] = 4'($urandom_range(1, MAX_LEN));
      end
      for (int k = 0; k < 150; k++) begin
        a = $urandom_range(0, 15);
        case (a)
          6: press(B_CFM);
          7: press(B_CLR);
          8: press(B_SEL);
          9: begin
            if ($urandom_range(0, 1) == 1) press(B_SEL);
            type_bits(slot_pw(m_slot), slot_len(m_slot));
            press(B_CFM);
          end
          10: idle($urandom_range(1, 40));
          11: idle($urandom_range(340, 380));
          12: begin
            @(negedge clock);
            {algorithm_select_mode, clear, confirm, enter1, enter0} = 5'($urandom);
            lim = $urandom_range(0, 2);
            repeat (lim) @(negedge clock);
            @(negedge clock);
            {algorithm_select_mode, clear, confirm, enter1, enter0} = '0;
          end
          13: begin
            @(negedge clock); enter0 = 1; enter1 = 1;
            @(negedge clock); enter0 = 0; enter1 = 0;
          end
          default: press($urandom_range(0, 1) == 1 ? B_E1 : B_E0);
        endcase
      end
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
